// File: rtl/ex_pkg.sv
// Shared constants and the registered EX/MEM payload for the execute stage.
// The payload gains an overflow flag when EX_OVERFLOW_EN is defined.
package ex_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  // Unlisted funct codes map here and yield a zero result
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  typedef struct packed {
    logic [XLEN-1:0]  add_result;
    logic             zero;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  rdata2;
    logic [REG_W-1:0] dst;
    logic [1:0]       wb_ctl;
    logic [2:0]       m_ctl;
`ifdef EX_OVERFLOW_EN
    logic             ovf;
`endif
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
// overflow_out exists only when EX_OVERFLOW_EN is defined.
interface ex_mem_stage_if;
  import ex_pkg::*;

  logic             stall;
  logic             flush;
  logic [XLEN-1:0]  npc;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic [XLEN-1:0]  s_extend;
  logic [REG_W-1:0] instr_2016;
  logic [REG_W-1:0] instr_1511;
  logic [1:0]       wb_ctl;
  logic [2:0]       m_ctl;
  logic [3:0]       ex_ctl;

  logic [XLEN-1:0]  add_result;
  logic             zero;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  rdata2out;
  logic [REG_W-1:0] muxout;
  logic [1:0]       wb_ctlout;
  logic [2:0]       m_ctlout;
`ifdef EX_OVERFLOW_EN
  logic             overflow_out;
`endif

  modport master (
    output stall, flush, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
           wb_ctl, m_ctl, ex_ctl,
    input  add_result, zero, alu_result, rdata2out, muxout, wb_ctlout, m_ctlout
`ifdef EX_OVERFLOW_EN
         , overflow_out
`endif
  );

  modport slave (
    input  stall, flush, npc, rdata1, rdata2, s_extend, instr_2016, instr_1511,
           wb_ctl, m_ctl, ex_ctl,
    output add_result, zero, alu_result, rdata2out, muxout, wb_ctlout, m_ctlout
`ifdef EX_OVERFLOW_EN
         , overflow_out
`endif
  );

endinterface

// File: rtl/ex_alu.sv
// Combinational ALU-control decode and ALU datapath.
// Signed add/sub overflow output is present only with EX_OVERFLOW_EN.
module ex_alu
  import ex_pkg::*;
(
  input  logic [1:0]      alu_op_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o_c,
  output logic            zero_o_c
`ifdef EX_OVERFLOW_EN
, output logic            ovf_o_c
`endif
);

  logic [3:0]      sel;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    sel = ALU_ADD;
    if (alu_op_i == ALUOP_SUB) begin
      sel = ALU_SUB;
    end else if (alu_op_i == ALUOP_FUNCT) begin
      case (funct_i)
        FUNCT_ADD: sel = ALU_ADD;
        FUNCT_SUB: sel = ALU_SUB;
        FUNCT_AND: sel = ALU_AND;
        FUNCT_OR:  sel = ALU_OR;
        FUNCT_NOR: sel = ALU_NOR;
        FUNCT_SLT: sel = ALU_SLT;
        default:   sel = ALU_NONE;
      endcase
    end
  end

  always_comb begin
    result_o_c = '0;
    case (sel)
      ALU_ADD: result_o_c = sum;
      ALU_SUB: result_o_c = diff;
      ALU_AND: result_o_c = a_i & b_i;
      ALU_OR:  result_o_c = a_i | b_i;
      ALU_NOR: result_o_c = ~(a_i | b_i);
      ALU_SLT: result_o_c = ($signed(a_i) < $signed(b_i)) ? XLEN'(1) : '0;
      default: result_o_c = '0;
    endcase
  end

  assign zero_o_c = (result_o_c == '0);

`ifdef EX_OVERFLOW_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips
  always_comb begin
    ovf_o_c = 1'b0;
    if (sel == ALU_ADD) begin
      ovf_o_c = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
    end else if (sel == ALU_SUB) begin
      ovf_o_c = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
    end
  end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register (stall hold, flush bubble).
// Optional feature macro: EX_OVERFLOW_EN adds overflow_out and squashes writes on overflow.
module ex_mem_stage
  import ex_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  ex_mem_stage_if.slave  bus
);

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
`ifdef EX_OVERFLOW_EN
  logic            alu_ovf;
`endif
  ex_mem_t         ex_mem_d;
  ex_mem_t         ex_mem_q;

  assign op_b = bus.ex_ctl[EX_ALUSRC] ? bus.s_extend : bus.rdata2;

  ex_alu u_alu (
    .alu_op_i   (bus.ex_ctl[EX_ALUOP_HI:EX_ALUOP_LO]),
    .funct_i    (bus.s_extend[5:0]),
    .a_i        (bus.rdata1),
    .b_i        (op_b),
    .result_o_c (alu_res),
    .zero_o_c   (alu_zero)
`ifdef EX_OVERFLOW_EN
  , .ovf_o_c    (alu_ovf)
`endif
  );

  // Next-state: hold on stall unless flush forces a bubble load
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (bus.flush || !bus.stall) begin
      ex_mem_d.add_result = bus.npc + (bus.s_extend << 2);
      ex_mem_d.zero       = alu_zero;
      ex_mem_d.alu_result = alu_res;
      ex_mem_d.rdata2     = bus.rdata2;
      ex_mem_d.dst        = bus.ex_ctl[EX_REGDST] ? bus.instr_1511 : bus.instr_2016;
      ex_mem_d.wb_ctl     = bus.wb_ctl;
      ex_mem_d.m_ctl      = bus.m_ctl;
`ifdef EX_OVERFLOW_EN
      ex_mem_d.ovf        = alu_ovf;
      if (alu_ovf) begin
        ex_mem_d.wb_ctl               = '0;
        ex_mem_d.m_ctl[M_MEMWRITE]    = 1'b0;
      end
`endif
      if (bus.flush) begin
        ex_mem_d.wb_ctl = '0;
        ex_mem_d.m_ctl  = '0;
`ifdef EX_OVERFLOW_EN
        ex_mem_d.ovf    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign bus.add_result = ex_mem_q.add_result;
  assign bus.zero       = ex_mem_q.zero;
  assign bus.alu_result = ex_mem_q.alu_result;
  assign bus.rdata2out  = ex_mem_q.rdata2;
  assign bus.muxout     = ex_mem_q.dst;
  assign bus.wb_ctlout  = ex_mem_q.wb_ctl;
  assign bus.m_ctlout   = ex_mem_q.m_ctl;
`ifdef EX_OVERFLOW_EN
  assign bus.overflow_out = ex_mem_q.ovf;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage against an arithmetic reference model.
// Build with EX_OVERFLOW_EN defined to also exercise the overflow feature.
module tb_ex_mem_stage;

`ifdef EX_OVERFLOW_EN
  localparam int unsigned OUT_W = 108;
`else
  localparam int unsigned OUT_W = 107;
`endif

  logic clk;
  logic reset;
  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q;

  function automatic logic [OUT_W-1:0] actual();
    actual = {bus.add_result, bus.zero, bus.alu_result, bus.rdata2out,
              bus.muxout, bus.wb_ctlout, bus.m_ctlout
`ifdef EX_OVERFLOW_EN
            , bus.overflow_out
`endif
             };
  endfunction

  // Reference: what the stage should capture from the current inputs
  function automatic logic [OUT_W-1:0] model_next();
    logic [31:0] a, b, res, tgt;
    logic [4:0]  dst;
    logic [1:0]  wb;
    logic [2:0]  m;
    int          kind;
`ifdef EX_OVERFLOW_EN
    longint      wide;
    logic        ovf;
    wide = 0;
`endif
    a = bus.rdata1;
    b = bus.ex_ctl[0] ? bus.s_extend : bus.rdata2;
    if (bus.ex_ctl[2:1] == 2'b01) kind = 1;
    else if (bus.ex_ctl[2:1] == 2'b10) begin
      case (bus.s_extend[5:0])
        6'h20: kind = 0;
        6'h22: kind = 1;
        6'h24: kind = 2;
        6'h25: kind = 3;
        6'h27: kind = 4;
        6'h2A: kind = 5;
        default: kind = 6;
      endcase
    end else kind = 0;
    case (kind)
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = ~(a | b);
      5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    tgt = bus.npc + bus.s_extend * 4;
    dst = bus.ex_ctl[3] ? bus.instr_1511 : bus.instr_2016;
    wb  = bus.wb_ctl;
    m   = bus.m_ctl;
`ifdef EX_OVERFLOW_EN
    if (kind == 0) wide = longint'($signed(a)) + longint'($signed(b));
    if (kind == 1) wide = longint'($signed(a)) - longint'($signed(b));
    ovf = (kind <= 1) && ((wide > 64'sd2147483647) || (wide < -64'sd2147483648));
    if (ovf) begin
      wb   = 2'b00;
      m[0] = 1'b0;
    end
    if (bus.flush) ovf = 1'b0;
`endif
    if (bus.flush) begin
      wb = 2'b00;
      m  = 3'b000;
    end
    model_next = {tgt, (res == 32'd0), res, bus.rdata2, dst, wb, m
`ifdef EX_OVERFLOW_EN
                , ovf
`endif
                 };
  endfunction

  task automatic tick();
    if (reset) exp_q = '0;
    else if (bus.flush || !bus.stall) exp_q = model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.npc        = $urandom();
    bus.rdata1     = $urandom();
    bus.rdata2     = $urandom();
    bus.s_extend   = $urandom();
    bus.instr_2016 = 5'($urandom());
    bus.instr_1511 = 5'($urandom());
    bus.wb_ctl     = 2'($urandom());
    bus.m_ctl      = 3'($urandom());
    bus.ex_ctl     = 4'($urandom());
    case ($urandom_range(7))
      0: bus.s_extend[5:0] = 6'h20;
      1: bus.s_extend[5:0] = 6'h22;
      2: bus.s_extend[5:0] = 6'h24;
      3: bus.s_extend[5:0] = 6'h25;
      4: bus.s_extend[5:0] = 6'h27;
      5: bus.s_extend[5:0] = 6'h2A;
      default: ;
    endcase
    if ($urandom_range(3) == 0) bus.rdata2 = bus.rdata1;
  endtask

  task automatic test_reset();
    rand_inputs();
    reset     = 1'b1;
    bus.stall = 1'($urandom());
    bus.flush = 1'($urandom());
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (actual() !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want 0", i, actual());
      end
      rand_inputs();
    end
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_sub_zero();
    rand_inputs();
    bus.ex_ctl   = 4'b0100;
    bus.s_extend[5:0] = 6'b100010;
    bus.rdata1   = 32'd5;
    bus.rdata2   = 32'd5;
    tick();
    checks++;
    if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: got alu=%h zero=%b want alu=0 zero=1", bus.alu_result, bus.zero);
    end
    checks++;
    if (actual() !== exp_q) begin
      errors++;
      $display("FAIL sub_zero_all: got %h want %h", actual(), exp_q);
    end
  endtask

  task automatic test_slt();
    rand_inputs();
    bus.ex_ctl   = 4'b0100;
    bus.s_extend[5:0] = 6'b101010;
    bus.rdata1   = 32'hFFFF_FFFF;
    bus.rdata2   = 32'd1;
    tick();
    checks++;
    if (bus.alu_result !== 32'd1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL slt: got alu=%h zero=%b want alu=1 zero=0", bus.alu_result, bus.zero);
    end
  endtask

  task automatic test_branch();
    rand_inputs();
    bus.npc      = 32'h100;
    bus.s_extend = 32'hFFFF_FFFE;
    bus.ex_ctl[3] = 1'b0;
    tick();
    checks++;
    if (bus.add_result !== 32'hF8 || bus.muxout !== bus.instr_2016) begin
      errors++;
      $display("FAIL branch: got tgt=%h dst=%0d want tgt=f8 dst=%0d",
               bus.add_result, bus.muxout, bus.instr_2016);
    end
    checks++;
    if (actual() !== exp_q) begin
      errors++;
      $display("FAIL branch_all: got %h want %h", actual(), exp_q);
    end
  endtask

  task automatic test_stall_flush();
    logic [OUT_W-1:0] held;
    rand_inputs();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();
    held = exp_q;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      checks++;
      if (actual() !== held) begin
        errors++;
        $display("FAIL stall[%0d]: got %h want %h", i, actual(), held);
      end
    end
    rand_inputs();
    bus.wb_ctl = 2'b11;
    bus.m_ctl  = 3'b111;
    bus.flush  = 1'b1;
    tick();
    checks++;
    if (bus.wb_ctlout !== 2'b00 || bus.m_ctlout !== 3'b000) begin
      errors++;
      $display("FAIL stall_flush: got wb=%b m=%b want 00 000", bus.wb_ctlout, bus.m_ctlout);
    end
    checks++;
    if (actual() !== exp_q) begin
      errors++;
      $display("FAIL stall_flush_all: got %h want %h", actual(), exp_q);
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      bus.stall = ($urandom_range(3) == 0);
      bus.flush = ($urandom_range(5) == 0);
      tick();
      checks++;
      if (actual() !== exp_q) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, actual(), exp_q);
      end
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rand_inputs();
    tick();
    rand_inputs();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    reset     = 1'b1;
    tick();
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", actual());
    end
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rand_inputs();
    tick();
    checks++;
    if (actual() !== exp_q) begin
      errors++;
      $display("FAIL resume: got %h want %h", actual(), exp_q);
    end
  endtask

`ifdef EX_OVERFLOW_EN
  task automatic test_overflow();
    rand_inputs();
    bus.ex_ctl = 4'b0000;
    bus.rdata1 = 32'h7FFF_FFFF;
    bus.rdata2 = 32'd1;
    bus.wb_ctl = 2'b10;
    bus.m_ctl  = 3'b001;
    tick();
    checks++;
    if (bus.overflow_out !== 1'b1 || bus.wb_ctlout !== 2'b00 ||
        bus.m_ctlout !== 3'b000 || bus.alu_result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL overflow: got ovf=%b wb=%b m=%b alu=%h want 1 00 000 80000000",
               bus.overflow_out, bus.wb_ctlout, bus.m_ctlout, bus.alu_result);
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    exp_q     = '0;
    test_reset();
    test_sub_zero();
    test_slt();
    test_branch();
    test_stall_flush();
    test_random();
    test_reset_midstream();
`ifdef EX_OVERFLOW_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there is no asynchronous path.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold all EX/MEM registers
- flush  in  1  insert bubble (control zeroed)
- npc  in  32  next PC from ID/EX
- rdata1  in  32  ALU operand A
- rdata2  in  32  operand B / store data
- s_extend  in  32  sign-extended immediate; [5:0] = funct
- instr_2016  in  5  rt
- instr_1511  in  5  rd
- wb_ctl  in  2  WB control, passed through
- m_ctl  in  3  [2] Branch, [1] MemRead, [0] MemWrite
- ex_ctl  in  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc
- add_result  out  32  registered branch target
- zero  out  1  registered ALU-zero flag
- alu_result  out  32  registered ALU result
- rdata2out  out  32  registered store data
- muxout  out  5  registered destination register
- wb_ctlout  out  2  registered WB control
- m_ctlout  out  3  registered M control

Function
REQ-003 Operand B SHALL be s_extend when ALUSrc=1, otherwise rdata2.
REQ-004 ALUOp decoding SHALL be:
- 00 → add
- 01 → sub
- 11 → add
- 10 → funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt
REQ-005 An unlisted funct SHALL produce an ALU result of 32'h0.
REQ-006 Add and sub SHALL be modulo 2^32; slt SHALL be a signed compare giving 32'h1 or 32'h0.
REQ-007 zero SHALL be 1 exactly when the ALU result is 32'h0.
REQ-008 The branch target SHALL be npc + (s_extend << 2), modulo 2^32, with bits shifted out discarded.
REQ-009 muxout SHALL be instr_1511 when RegDst=1, otherwise instr_2016.
REQ-010 Latency SHALL be one cycle: every output is updated on the clk edge following its inputs.
REQ-011 With stall=1 and flush=0, all outputs SHALL hold their values.
REQ-012 With flush=1, wb_ctlout and m_ctlout SHALL load 0 and the data outputs SHALL load normally.
REQ-013 Flush SHALL take priority over stall.
REQ-014 No output SHALL depend combinationally on any input.

Reset
REQ-015 When reset=1 at a clk edge, all outputs SHALL become 0, overriding stall and flush.
REQ-016 Reset asserted mid-stream SHALL discard the in-flight instruction.
REQ-017 Outputs SHALL resume updating on the first edge after reset=0.

Configuration
REQ-018 With EX_OVERFLOW_EN defined, the block SHALL add port overflow_out (out, 1, registered signed overflow of an add/sub).
REQ-019 With EX_OVERFLOW_EN defined and overflow detected, wb_ctlout SHALL be 00 and m_ctlout[0] SHALL be 0; alu_result SHALL still hold the wrapped value.
REQ-020 Without EX_OVERFLOW_EN, the overflow_out port SHALL be absent and results SHALL wrap silently.
REQ-021 overflow_out SHALL reset to 0, hold under stall, and clear on flush.

Structure
REQ-022 Package ex_pkg SHALL hold the ALUOp codes, the funct constants, the internal 4-bit ALU select codes (add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100) and the ex_ctl/m_ctl bit-index constants.
REQ-023 The ALU-control decode and ALU datapath SHALL be combinational sub-module ex_alu; the operand muxes, branch adder and registers SHALL stay in the top level.

Verification
REQ-024 reset=1 for 2 cycles with random inputs → all outputs 0.
REQ-025 ALUOp=10, funct=100010, rdata1=5, rdata2=5 → alu_result=0, zero=1 next cycle.
REQ-026 ALUOp=10, funct=101010, rdata1=32'hFFFFFFFF, rdata2=1 → alu_result=1.
REQ-027 npc=32'h100, s_extend=32'hFFFFFFFE → add_result=32'hF8; with RegDst=0 → muxout=rt.
REQ-028 stall=1 for 3 cycles with changing inputs → outputs frozen; stall=1 and flush=1 → wb_ctlout=0, m_ctlout=0.
REQ-029 With EX_OVERFLOW_EN: add 32'h7FFFFFFF + 1, wb_ctl=10, m_ctl=001 → overflow_out=1, wb_ctlout=00, m_ctlout=000, alu_result=32'h80000000.
